// File: rtl/r2_lut_addr_gen_if.sv
// Handshake/bus bundle for the r2 LUT address generator.
// The master drives samples in; the slave returns address, aligned r2 and stats.
interface r2_lut_addr_gen_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
);
  logic [31:0]           r2_in;
  logic                  r2_valid;
  logic                  cnt_clear;
  logic [ADDR_WIDTH-1:0] lut_address;
  logic                  lut_rden;
  logic [31:0]           r2_out;
  logic                  out_valid;
  logic                  out_underflow;
  logic [CNT_WIDTH-1:0]  reject_count;
  logic [CNT_WIDTH-1:0]  underflow_count;

  modport master (
    output r2_in, r2_valid, cnt_clear,
    input  lut_address, lut_rden, r2_out, out_valid,
    input  out_underflow, reject_count, underflow_count
  );

  modport slave (
    input  r2_in, r2_valid, cnt_clear,
    output lut_address, lut_rden, r2_out, out_valid,
    output out_underflow, reject_count, underflow_count
  );
endinterface

// File: rtl/r2_lut_addr_gen.sv
// Segment/bin address generator for the LJ force interpolation tables.
// Classifies float32 r2 and delays it to line up with the table read data.
module r2_lut_addr_gen #(
  parameter int          SEGMENT_NUM = 12,
  parameter int          BIN_BITS    = 8,
  parameter int          ADDR_WIDTH  = 12,
  parameter int          EXP_START   = 124,
  parameter logic [31:0] CUTOFF_R2   = 32'h43100000,
  parameter int          LUT_LATENCY = 2,
  parameter int          CNT_WIDTH   = 16
) (
  input logic clock,
  input logic rst,
  r2_lut_addr_gen_if.slave bus
);

  localparam int SEG_W = ADDR_WIDTH - BIN_BITS;
  localparam logic [7:0] EXP_LO = 8'(EXP_START);
  localparam logic [7:0] EXP_HI = 8'(EXP_START + SEGMENT_NUM);

  logic [31:0]           s0_r2_q;
  logic                  s0_v_q;
  logic [7:0]            exp_w;
  logic [SEG_W-1:0]      seg_w;
  logic                  reject_w;
  logic                  under_w;
  logic                  rden_d, rden_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [31:0]           s1_r2_d, s1_r2_q;
  logic                  s1_uf_d, s1_uf_q;
  logic [CNT_WIDTH-1:0]  rej_cnt_d, rej_cnt_q;
  logic [CNT_WIDTH-1:0]  uf_cnt_d, uf_cnt_q;
  logic                  dl_v_q  [LUT_LATENCY];
  logic [31:0]           dl_r2_q [LUT_LATENCY];
  logic                  dl_uf_q [LUT_LATENCY];

  // S0: register the raw input sample every cycle
  always_ff @(posedge clock) begin
    if (rst) begin
      s0_r2_q <= '0;
      s0_v_q  <= 1'b0;
    end else begin
      s0_r2_q <= bus.r2_in;
      s0_v_q  <= bus.r2_valid;
    end
  end

  // S1 next state: classify, form address, update saturating counters
  always_comb begin
    exp_w    = s0_r2_q[30:23];
    seg_w    = SEG_W'(exp_w - EXP_LO);
    reject_w = s0_r2_q[31]
             | (exp_w == 8'hFF)
             | (s0_r2_q[30:0] >= CUTOFF_R2[30:0])
             | (exp_w >= EXP_HI);
    under_w  = !reject_w && (exp_w < EXP_LO);
    rden_d   = s0_v_q && !reject_w;
    addr_d   = addr_q;
    s1_r2_d  = s1_r2_q;
    s1_uf_d  = rden_d && under_w;
    if (rden_d) begin
      s1_r2_d = s0_r2_q;
      if (under_w) addr_d = '0;
      else addr_d = {seg_w, s0_r2_q[22 -: BIN_BITS]};
    end
    rej_cnt_d = rej_cnt_q;
    uf_cnt_d  = uf_cnt_q;
    if (bus.cnt_clear) begin
      rej_cnt_d = '0;
      uf_cnt_d  = '0;
    end else begin
      if (s0_v_q && reject_w && rej_cnt_q != '1)
        rej_cnt_d = rej_cnt_q + 1'b1;
      if (s0_v_q && under_w && uf_cnt_q != '1)
        uf_cnt_d = uf_cnt_q + 1'b1;
    end
  end

  // S1: address/enable register and statistics counters
  always_ff @(posedge clock) begin
    if (rst) begin
      rden_q    <= 1'b0;
      addr_q    <= '0;
      s1_r2_q   <= '0;
      s1_uf_q   <= 1'b0;
      rej_cnt_q <= '0;
      uf_cnt_q  <= '0;
    end else begin
      rden_q    <= rden_d;
      addr_q    <= addr_d;
      s1_r2_q   <= s1_r2_d;
      s1_uf_q   <= s1_uf_d;
      rej_cnt_q <= rej_cnt_d;
      uf_cnt_q  <= uf_cnt_d;
    end
  end

  // Delay line matching the table read latency; r2 only moves with a valid
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < LUT_LATENCY; i++) begin
        dl_v_q[i]  <= 1'b0;
        dl_r2_q[i] <= '0;
        dl_uf_q[i] <= 1'b0;
      end
    end else begin
      dl_v_q[0]  <= rden_q;
      dl_uf_q[0] <= rden_q & s1_uf_q;
      if (rden_q) dl_r2_q[0] <= s1_r2_q;
      for (int i = 1; i < LUT_LATENCY; i++) begin
        dl_v_q[i]  <= dl_v_q[i-1];
        dl_uf_q[i] <= dl_v_q[i-1] & dl_uf_q[i-1];
        if (dl_v_q[i-1]) dl_r2_q[i] <= dl_r2_q[i-1];
      end
    end
  end

  assign bus.lut_address     = addr_q;
  assign bus.lut_rden        = rden_q;
  assign bus.r2_out          = dl_r2_q[LUT_LATENCY-1];
  assign bus.out_valid       = dl_v_q[LUT_LATENCY-1];
  assign bus.out_underflow   = dl_uf_q[LUT_LATENCY-1];
  assign bus.reject_count    = rej_cnt_q;
  assign bus.underflow_count = uf_cnt_q;

endmodule

// File: tb/tb_r2_lut_addr_gen.sv
// Directed-vector and streaming bench for r2_lut_addr_gen.
// Expected values come from hand-computed tables and a small reference model.
module tb_r2_lut_addr_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  r2_lut_addr_gen_if bus ();

  r2_lut_addr_gen dut (
    .clock (clk),
    .rst   (rst),
    .bus   (bus)
  );

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] r2;
    logic        rden;
    logic [11:0] addr;
    logic        uf;
  } vec_t;

  localparam int NV = 11;
  localparam int NS = 1000;

  vec_t        tbl [NV];
  logic [11:0] last_addr;
  logic [31:0] last_r2o;
  int          n_rej;
  int          n_uf;

  logic [31:0] s_r2   [NS];
  logic        s_rd   [NS];
  logic        s_uf   [NS];
  logic [11:0] s_addr [NS];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] r, output logic rd,
                                output logic [11:0] a, output logic uf,
                                output logic rj);
    logic [7:0] e;
    logic [7:0] sg;
    e  = r[30:23];
    sg = e - 8'd124;
    rj = r[31] || (e == 8'hFF) || (r[30:0] >= 31'h43100000) || (e >= 8'd136);
    uf = !rj && (e < 8'd124);
    rd = !rj;
    a  = uf ? 12'd0 : {sg[3:0], r[22:15]};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    bus.r2_in = v.r2;
    bus.r2_valid = 1'b1;
    @(posedge clk); #1;
    bus.r2_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_rden"}, 32'(bus.lut_rden), 32'(v.rden));
    if (v.rden) last_addr = v.addr;
    chk({nm, "_addr"}, 32'(bus.lut_address), 32'(last_addr));
    @(posedge clk); #1;
    chk({nm, "_ov_early"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_ov"}, 32'(bus.out_valid), 32'(v.rden));
    if (v.rden) begin
      last_r2o = v.r2;
      chk({nm, "_uf"}, 32'(bus.out_underflow), 32'(v.uf));
    end
    chk({nm, "_r2o"}, bus.r2_out, last_r2o);
  endtask

  initial begin
    tbl[0]  = '{32'h3F800000, 1'b1, 12'd768,  1'b0};
    tbl[1]  = '{32'h3FC00000, 1'b1, 12'd896,  1'b0};
    tbl[2]  = '{32'h3E000000, 1'b1, 12'd0,    1'b0};
    tbl[3]  = '{32'h430F0000, 1'b1, 12'd2590, 1'b0};
    tbl[4]  = '{32'h3DCCCCCD, 1'b1, 12'd0,    1'b1};
    tbl[5]  = '{32'h00000000, 1'b1, 12'd0,    1'b1};
    tbl[6]  = '{32'h43100000, 1'b0, 12'd0,    1'b0};
    tbl[7]  = '{32'hBF800000, 1'b0, 12'd0,    1'b0};
    tbl[8]  = '{32'h7FC00000, 1'b0, 12'd0,    1'b0};
    tbl[9]  = '{32'h7F800000, 1'b0, 12'd0,    1'b0};
    tbl[10] = '{32'h430FFFFF, 1'b1, 12'd2591, 1'b0};

    bus.r2_in = '0;
    bus.r2_valid = 1'b0;
    bus.cnt_clear = 1'b0;
    rst = 1'b1;
    last_addr = '0;
    last_r2o = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rden", 32'(bus.lut_rden), 32'd0);
    chk("rst_addr", 32'(bus.lut_address), 32'd0);
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_r2o", bus.r2_out, 32'd0);
    chk("rst_uf", 32'(bus.out_underflow), 32'd0);
    chk("rst_rejc", 32'(bus.reject_count), 32'd0);
    chk("rst_ufc", 32'(bus.underflow_count), 32'd0);
    rst = 1'b0;

    // directed single-sample vectors
    n_rej = 0;
    n_uf = 0;
    for (int i = 0; i < NV; i++) begin
      run_vec(tbl[i], i);
      if (!tbl[i].rden) n_rej++;
      if (tbl[i].uf) n_uf++;
      if (i == 5) chk("ufc_after_zero", 32'(bus.underflow_count), 32'd2);
      if (i == 8) chk("rejc_after_three", 32'(bus.reject_count), 32'd3);
    end
    chk("tbl_rejc", 32'(bus.reject_count), 32'(n_rej));
    chk("tbl_ufc", 32'(bus.underflow_count), 32'(n_uf));

    // back-to-back random stream against the model
    @(posedge clk); #1;
    bus.cnt_clear = 1'b1;
    @(posedge clk); #1;
    bus.cnt_clear = 1'b0;
    n_rej = 0;
    n_uf = 0;
    begin
      logic [11:0] ha;
      logic [11:0] a;
      logic rd, uf, rj;
      logic [31:0] r;
      ha = last_addr;
      for (int i = 0; i < NS; i++) begin
        case ($urandom_range(0, 4))
          0: r = {1'b0, 8'($urandom_range(124, 134)), 23'($urandom)};
          1: r = 32'h43100000;
          2: r = {1'b0, 8'($urandom_range(0, 123)), 23'($urandom)};
          3: r = $urandom;
          default: r = {1'b0, 8'($urandom_range(120, 140)), 23'($urandom)};
        endcase
        model(r, rd, a, uf, rj);
        if (rd) ha = a;
        s_r2[i] = r;
        s_rd[i] = rd;
        s_uf[i] = uf;
        s_addr[i] = ha;
        if (rj) n_rej++;
        if (uf) n_uf++;
      end
    end
    for (int k = 0; k < NS + 4; k++) begin
      @(posedge clk); #1;
      if (k >= 2 && k - 2 < NS) begin
        chk($sformatf("s%0d_rden", k - 2), 32'(bus.lut_rden), 32'(s_rd[k-2]));
        chk($sformatf("s%0d_addr", k - 2), 32'(bus.lut_address),
            32'(s_addr[k-2]));
      end
      if (k >= 4) begin
        chk($sformatf("s%0d_ov", k - 4), 32'(bus.out_valid), 32'(s_rd[k-4]));
        if (s_rd[k-4]) begin
          last_r2o = s_r2[k-4];
          chk($sformatf("s%0d_uf", k - 4), 32'(bus.out_underflow),
              32'(s_uf[k-4]));
        end
        chk($sformatf("s%0d_r2o", k - 4), bus.r2_out, last_r2o);
      end else begin
        chk($sformatf("pre%0d_ov", k), 32'(bus.out_valid), 32'd0);
      end
      if (k < NS) begin
        bus.r2_in = s_r2[k];
        bus.r2_valid = 1'b1;
      end else begin
        bus.r2_valid = 1'b0;
      end
    end
    chk("stream_rejc", 32'(bus.reject_count), 32'(n_rej));
    chk("stream_ufc", 32'(bus.underflow_count), 32'(n_uf));

    // reject counter saturation
    @(posedge clk); #1;
    bus.r2_in = 32'hBF800000;
    bus.r2_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    bus.r2_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rejc_sat", 32'(bus.reject_count), 32'h0000FFFF);

    // clear wins over a same-cycle increment
    bus.r2_in = 32'hBF800000;
    bus.r2_valid = 1'b1;
    @(posedge clk); #1;
    bus.r2_valid = 1'b0;
    bus.cnt_clear = 1'b1;
    @(posedge clk); #1;
    bus.cnt_clear = 1'b0;
    chk("rejc_clear", 32'(bus.reject_count), 32'd0);
    chk("ufc_clear", 32'(bus.underflow_count), 32'd0);
    bus.r2_valid = 1'b1;
    @(posedge clk); #1;
    bus.r2_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rejc_after_clear", 32'(bus.reject_count), 32'd1);

    // reset with samples in flight
    bus.r2_in = 32'h3F800000;
    bus.r2_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.r2_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_r2o", bus.r2_out, 32'd0);
    chk("mid_rst_rejc", 32'(bus.reject_count), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("mid_rst_ov%0d", k), 32'(bus.out_valid), 32'd0);
      chk($sformatf("mid_rst_rden%0d", k), 32'(bus.lut_rden), 32'd0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
